// File: rtl/mont_mul_param_pkg.sv
// Shared definitions for the parametrised radix-2 Montgomery multiplier:
// operand select codes for the load bus, FSM state encoding and a small
// width helper used for parameter defaults.
package mont_mul_param_pkg;

  // Operand select codes on in_operand (2'b11 is ignored by the unit).
  localparam logic [1:0] MONT_MUL_OPERAND_A = 2'b00;
  localparam logic [1:0] MONT_MUL_OPERAND_B = 2'b01;
  localparam logic [1:0] MONT_MUL_OPERAND_N = 2'b10;

  // Controller states.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_RUNNING = 2'b01,
    ST_CLEANUP = 2'b10,
    ST_FINISH  = 2'b11
  } mont_state_e;

  // Index width for a range of v entries, never narrower than one bit.
  function automatic int clog2_min1(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/mont_mul_param_step.sv
// One radix-2 Montgomery iteration, purely combinational:
//   t = M + (a_bit ? B : 0); t = t + (t[0] ? N : 0); next M = t >> 1.
// All arithmetic is W+2 bits wide so nothing is lost before the shift.
// Kept separate so a radix-4 or multi-step datapath can replace it.
module mont_mul_param_step #(
  parameter int W = 128
) (
  input  logic [W+1:0] m,
  input  logic [W-1:0] b,
  input  logic [W-1:0] n,
  input  logic         a_bit,
  output logic [W+1:0] m_next
);

  logic [W+1:0] t_add_b;
  logic [W+1:0] t_add_n;

  // Add B when the current A bit is set, then add N to make the sum even.
  always_comb begin
    t_add_b = m + (a_bit ? {2'b00, b} : '0);
    t_add_n = t_add_b + (t_add_b[0] ? {2'b00, n} : '0);
    m_next  = t_add_n >> 1;
  end

endmodule

// File: rtl/mont_mul_param.sv
// Parametrised radix-2 Montgomery multiplier: result = A*B*2^-W mod N,
// W = WORD_W*NUM_WORDS. Operands are written word-serially while idle.
// A run takes W iteration cycles, one reduction cycle and one finish
// cycle; busy and valid are registered from the state of the previous
// cycle, so valid pulses W+2 cycles after the start edge.
// Handshake: loads are accepted on any posedge with in_valid=1, start=0
// and the unit idle; start is a level sampled on a posedge and is only
// honoured while idle. There is no back-pressure on either.
// Optional build macro: MONT_MUL_NCHECK_EN (reject even moduli at start,
// report through the sticky err flag).
module mont_mul_param
  import mont_mul_param_pkg::*;
#(
  parameter int WORD_W    = 32,
  parameter int NUM_WORDS = 4,
  parameter int OFS_W     = clog2_min1(NUM_WORDS)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  input  logic [WORD_W-1:0]           in_word,
  input  logic [1:0]                  in_operand,
  input  logic [OFS_W-1:0]            in_offset,
  input  logic                        start,
  output logic                        busy,
  output logic                        valid,
  output logic [WORD_W*NUM_WORDS-1:0] result,
  output logic                        err
);

  localparam int W     = WORD_W * NUM_WORDS;
  localparam int CNT_W = clog2_min1(W);

  mont_state_e      state_q, state_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic [W-1:0]     n_q, n_d;
  logic [W-1:0]     ash_q, ash_d;
  logic [W+1:0]     m_q, m_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]     result_q, result_d;
  logic             busy_q, busy_d;
  logic             valid_q, valid_d;
`ifdef MONT_MUL_NCHECK_EN
  logic             err_q, err_d;
`endif

  logic             load_ok;
  logic [W+1:0]     m_step;
  logic [W+1:0]     n_ext;

  assign n_ext   = {2'b00, n_q};
  assign load_ok = (state_q == ST_IDLE) && in_valid && !start &&
                   (int'(in_offset) < NUM_WORDS);

  mont_mul_param_step #(.W(W)) u_step (
    .m      (m_q),
    .b      (b_q),
    .n      (n_q),
    .a_bit  (ash_q[0]),
    .m_next (m_step)
  );

  // Operand loads, next-state logic and per-state datapath updates.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    n_d      = n_q;
    ash_d    = ash_q;
    m_d      = m_q;
    cnt_d    = cnt_q;
    result_d = result_q;
`ifdef MONT_MUL_NCHECK_EN
    err_d    = err_q;
`endif
    busy_d   = (state_q != ST_IDLE);
    valid_d  = (state_q == ST_FINISH);

    if (load_ok) begin
      for (int i = 0; i < NUM_WORDS; i++) begin
        if (int'(in_offset) == i) begin
          case (in_operand)
            MONT_MUL_OPERAND_A: a_d[i*WORD_W +: WORD_W] = in_word;
            MONT_MUL_OPERAND_B: b_d[i*WORD_W +: WORD_W] = in_word;
            MONT_MUL_OPERAND_N: n_d[i*WORD_W +: WORD_W] = in_word;
            default: ;
          endcase
        end
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          m_d   = '0;
          cnt_d = '0;
          ash_d = a_q;
`ifdef MONT_MUL_NCHECK_EN
          if (!n_q[0]) begin
            result_d = '0;
            err_d    = 1'b1;
            state_d  = ST_FINISH;
          end else begin
            err_d    = 1'b0;
            state_d  = ST_RUNNING;
          end
`else
          state_d = ST_RUNNING;
`endif
        end
      end
      ST_RUNNING: begin
        m_d   = m_step;
        ash_d = ash_q >> 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(W - 1)) begin
          state_d = ST_CLEANUP;
        end
      end
      ST_CLEANUP: begin
        result_d = W'((m_q >= n_ext) ? (m_q - n_ext) : m_q);
        state_d  = ST_FINISH;
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      n_q      <= '0;
      ash_q    <= '0;
      m_q      <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
`ifdef MONT_MUL_NCHECK_EN
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      n_q      <= n_d;
      ash_q    <= ash_d;
      m_q      <= m_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      valid_q  <= valid_d;
`ifdef MONT_MUL_NCHECK_EN
      err_q    <= err_d;
`endif
    end
  end

  assign busy   = busy_q;
  assign valid  = valid_q;
  assign result = result_q;
`ifdef MONT_MUL_NCHECK_EN
  assign err    = err_q;
`else
  assign err    = 1'b0;
`endif

endmodule

// File: tb/tb_mont_mul_param.sv
// Bench for mont_mul_param: an 8-bit instance (WORD_W=8, NUM_WORDS=1)
// and a default 128-bit instance share one set of drivers; sel steers
// in_valid/start to one of them and muxes its outputs for checking.
module tb_mont_mul_param;
  import mont_mul_param_pkg::*;

  // ---------------- clock / reset / drivers ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start;
  logic        in_valid;
  logic        sel;
  logic [1:0]  in_operand;
  logic [1:0]  in_offset;
  logic [31:0] in_word;

  logic         busy8, valid8, err8;
  logic [7:0]   result8;
  logic         busy_b, valid_b, err_b;
  logic [127:0] result_b;

  logic         cur_busy, cur_valid, cur_err;
  logic [255:0] cur_result;

  int checks   = 0;
  int failures = 0;

  mont_mul_param #(.WORD_W(8), .NUM_WORDS(1)) dut8 (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid & ~sel),
    .in_word    (in_word[7:0]),
    .in_operand (in_operand),
    .in_offset  (in_offset[0]),
    .start      (start & ~sel),
    .busy       (busy8),
    .valid      (valid8),
    .result     (result8),
    .err        (err8)
  );

  mont_mul_param dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid & sel),
    .in_word    (in_word),
    .in_operand (in_operand),
    .in_offset  (in_offset),
    .start      (start & sel),
    .busy       (busy_b),
    .valid      (valid_b),
    .result     (result_b),
    .err        (err_b)
  );

  assign cur_busy   = sel ? busy_b  : busy8;
  assign cur_valid  = sel ? valid_b : valid8;
  assign cur_err    = sel ? err_b   : err8;
  assign cur_result = sel ? {128'b0, result_b} : {248'b0, result8};

  // ---------------- reference model ----------------
  // A*B*2^-w mod n: reduce the product, then divide by two w times in
  // the ring of integers mod n (odd n makes halving well defined).
  function automatic logic [255:0] mont_model(input logic [255:0] a,
                                              input logic [255:0] b,
                                              input logic [255:0] n,
                                              input int w);
    logic [255:0] x;
    x = (a * b) % n;
    for (int i = 0; i < w; i++) x = x[0] ? ((x + n) >> 1) : (x >> 1);
    return x;
  endfunction

  // ---------------- scoreboard helpers ----------------
  task automatic check(input bit ok, input string name, input string detail);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: %s", name, detail);
    end
  endtask

  task automatic load_word(input logic [1:0] op, input logic [1:0] ofs, input logic [31:0] w);
    @(negedge clk);
    in_valid   = 1'b1;
    in_operand = op;
    in_offset  = ofs;
    in_word    = w;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic load_op(input logic [1:0] op, input logic [127:0] v, input bit rev);
    int nw;
    int ww;
    int o;
    logic [127:0] sh;
    logic [31:0]  w;
    nw = sel ? 4 : 1;
    ww = sel ? 32 : 8;
    for (int i = 0; i < nw; i++) begin
      o  = rev ? (nw - 1 - i) : i;
      sh = v >> (o * ww);
      w  = sh[31:0];
      if (!sel) w = {24'b0, w[7:0]};
      load_word(op, 2'(o), w);
    end
  endtask

  task automatic load_abn(input logic [127:0] a, input logic [127:0] b,
                          input logic [127:0] n, input bit rev);
    load_op(MONT_MUL_OPERAND_N, n, rev);
    load_op(MONT_MUL_OPERAND_A, a, rev);
    load_op(MONT_MUL_OPERAND_B, b, rev);
  endtask

  // Start one run and watch it. Optional extra events, given as posedge
  // indices counted from the start edge (0 = unused): a second start, a
  // load-plus-start disturbance, or a reset. Expected valid cycles come
  // from the rule that a start is honoured only lat+1 or more edges
  // after the previously honoured one.
  task automatic run_op(input string name, input logic [255:0] exp_res,
                        input bit exp_err, input int lat,
                        input int restart_edge, input int disturb_edge,
                        input int rst_edge, input bit load_at_start);
    int  starts[$];
    int  exp_v[$];
    int  got_v[$];
    int  limit;
    int  busy_bad;
    bit  exp_busy;
    bit  same;
    starts.push_back(0);
    if (restart_edge > 0 && restart_edge >= lat + 1) starts.push_back(restart_edge);
    if (disturb_edge > 0 && disturb_edge >= lat + 1) starts.push_back(disturb_edge);
    foreach (starts[i])
      if (rst_edge == 0 || starts[i] + lat < rst_edge) exp_v.push_back(starts[i] + lat);
    limit = lat;
    if (restart_edge + lat > limit) limit = restart_edge + lat;
    if (disturb_edge + lat > limit) limit = disturb_edge + lat;
    limit += 3;
    busy_bad = 0;

    @(negedge clk);
    start = 1'b1;
    if (load_at_start) begin
      in_valid = 1'b1; in_operand = MONT_MUL_OPERAND_A; in_offset = 2'd0; in_word = 32'hFF;
    end
    @(posedge clk);
    for (int cyc = 1; cyc <= limit; cyc++) begin
      @(negedge clk);
      start = 1'b0; in_valid = 1'b0; rst_n = 1'b1;
      if (cyc == restart_edge) start = 1'b1;
      if (cyc == disturb_edge) begin
        start = 1'b1; in_valid = 1'b1; in_operand = MONT_MUL_OPERAND_A;
        in_offset = 2'd0; in_word = 32'hFF;
      end
      if (cyc == rst_edge) rst_n = 1'b0;
      @(posedge clk);
      #1;
      exp_busy = 1'b0;
      foreach (starts[i]) if (cyc >= starts[i] + 1 && cyc <= starts[i] + lat) exp_busy = 1'b1;
      if (rst_edge > 0 && cyc >= rst_edge) exp_busy = 1'b0;
      if (cur_busy !== exp_busy) busy_bad++;
      if (cur_valid === 1'b1) begin
        got_v.push_back(cyc);
        check(cur_result === exp_res && cur_err === exp_err, {name, " result"},
              $sformatf("cycle %0d got result=%h err=%b, expected result=%h err=%b",
                        cyc, cur_result, cur_err, exp_res, exp_err));
      end
      if (rst_edge > 0 && cyc == rst_edge)
        check(cur_busy === 1'b0 && cur_result === '0 && cur_valid === 1'b0, {name, " after_reset"},
              $sformatf("got busy=%b valid=%b result=%h, expected all zero",
                        cur_busy, cur_valid, cur_result));
    end
    @(negedge clk);
    start = 1'b0; in_valid = 1'b0; rst_n = 1'b1;

    check(busy_bad == 0, {name, " busy"},
          $sformatf("%0d cycles with wrong busy, expected 0", busy_bad));
    same = (got_v.size() == exp_v.size());
    if (same) foreach (exp_v[i]) if (got_v[i] != exp_v[i]) same = 1'b0;
    check(same, {name, " valid_timing"},
          $sformatf("got %0d pulses (first at %0d), expected %0d pulses (first at %0d)",
                    got_v.size(), (got_v.size() > 0) ? got_v[0] : -1,
                    exp_v.size(), (exp_v.size() > 0) ? exp_v[0] : -1));
    if (rst_edge == 0)
      check(cur_result === exp_res && cur_err === exp_err, {name, " held"},
            $sformatf("got result=%h err=%b, expected result=%h err=%b",
                      cur_result, cur_err, exp_res, exp_err));
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] n;
    logic [7:0] r;
  } vec8_t;

  vec8_t tbl[7];

  initial begin : watchdog
    #2000000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : main
    logic [255:0] a, b, n, e;
    logic [127:0] r;
    int prev_n;

    // Hand-derived: 2^8 mod 13 = 9, 9^-1 mod 13 = 3; 2^8 mod 255 = 1.
    tbl[0] = '{a: 8'd5,   b: 8'd7,   n: 8'd13,  r: 8'd1};
    tbl[1] = '{a: 8'd1,   b: 8'd1,   n: 8'd13,  r: 8'd3};
    tbl[2] = '{a: 8'd12,  b: 8'd12,  n: 8'd13,  r: 8'd3};
    tbl[3] = '{a: 8'd0,   b: 8'd7,   n: 8'd13,  r: 8'd0};
    tbl[4] = '{a: 8'd2,   b: 8'd3,   n: 8'd13,  r: 8'd5};
    tbl[5] = '{a: 8'd12,  b: 8'd1,   n: 8'd13,  r: 8'd10};
    tbl[6] = '{a: 8'd200, b: 8'd100, n: 8'd255, r: 8'd110};

    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; sel = 1'b0;
    in_operand = 2'b00; in_offset = 2'b00; in_word = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check(busy8 === 1'b0 && valid8 === 1'b0, "reset8_flags",
          $sformatf("got busy=%b valid=%b, expected 0 0", busy8, valid8));
    check(result8 === 8'h0 && err8 === 1'b0, "reset8_result",
          $sformatf("got result=%h err=%b, expected 0 0", result8, err8));
    check(busy_b === 1'b0 && valid_b === 1'b0, "reset128_flags",
          $sformatf("got busy=%b valid=%b, expected 0 0", busy_b, valid_b));
    check(result_b === 128'h0 && err_b === 1'b0, "reset128_result",
          $sformatf("got result=%h err=%b, expected 0 0", result_b, err_b));
    @(negedge clk);
    rst_n = 1'b1;

    // 8-bit table; N reloaded only when it changes.
    sel = 1'b0;
    prev_n = -1;
    for (int i = 0; i < 7; i++) begin
      if (int'(tbl[i].n) != prev_n) load_op(MONT_MUL_OPERAND_N, {120'b0, tbl[i].n}, 1'b0);
      prev_n = int'(tbl[i].n);
      load_op(MONT_MUL_OPERAND_A, {120'b0, tbl[i].a}, 1'b0);
      load_op(MONT_MUL_OPERAND_B, {120'b0, tbl[i].b}, 1'b0);
      run_op($sformatf("tbl8[%0d]", i), {248'b0, tbl[i].r}, 1'b0, 10, 0, 0, 0, 1'b0);
    end

    // Out-of-range offset is dropped.
    load_abn(128'd5, 128'd7, 128'd13, 1'b0);
    load_word(MONT_MUL_OPERAND_A, 2'd1, 32'h09);
    run_op("ofs_drop", 256'd1, 1'b0, 10, 0, 0, 0, 1'b0);
    // Load in the same cycle as start is dropped; rerun without reload.
    run_op("load_at_start", 256'd1, 1'b0, 10, 0, 0, 0, 1'b1);
    run_op("rerun_no_reload", 256'd1, 1'b0, 10, 0, 0, 0, 1'b0);
    // Earliest accepted restart, and a start during FINISH that is ignored.
    run_op("back_to_back", 256'd1, 1'b0, 10, 11, 0, 0, 1'b0);
    run_op("start_in_finish", 256'd1, 1'b0, 10, 10, 0, 0, 1'b0);
    // Mid-run disturbance on the small unit.
    run_op("disturb8", 256'd1, 1'b0, 10, 0, 4, 0, 1'b0);

    // Reset during RUNNING, then prove operands were cleared.
    run_op("abort_a", 256'd1, 1'b0, 10, 0, 0, 5, 1'b0);
    load_op(MONT_MUL_OPERAND_N, 128'd13, 1'b0);
    load_op(MONT_MUL_OPERAND_B, 128'd7, 1'b0);
    run_op("a_cleared", 256'd0, 1'b0, 10, 0, 0, 0, 1'b0);
    load_op(MONT_MUL_OPERAND_A, 128'd5, 1'b0);
    run_op("abort_b", 256'd1, 1'b0, 10, 0, 0, 5, 1'b0);
    load_op(MONT_MUL_OPERAND_N, 128'd13, 1'b0);
    load_op(MONT_MUL_OPERAND_A, 128'd5, 1'b0);
    run_op("b_cleared", 256'd0, 1'b0, 10, 0, 0, 0, 1'b0);

`ifdef MONT_MUL_NCHECK_EN
    load_abn(128'd5, 128'd7, 128'd12, 1'b0);
    run_op("ncheck_even", 256'd0, 1'b1, 1, 0, 0, 0, 1'b0);
    load_op(MONT_MUL_OPERAND_N, 128'd13, 1'b0);
    run_op("ncheck_odd", 256'd1, 1'b0, 10, 0, 0, 0, 1'b0);
`endif

    // 128-bit unit.
    sel = 1'b1;
    n = {128'b0, 1'b1, 126'b0, 1'b1};
    load_abn(128'd0, n[127:0] - 128'd1, n[127:0], 1'b0);
    run_op("w128_zero", 256'd0, 1'b0, 130, 0, 0, 0, 1'b0);
    load_abn(128'd0, n[127:0] - 128'd1, n[127:0], 1'b1);
    run_op("w128_zero_rev", 256'd0, 1'b0, 130, 0, 0, 0, 1'b0);
    r = {$urandom, $urandom, $urandom, $urandom};
    a = {128'b0, r} % n;
    r = {$urandom, $urandom, $urandom, $urandom};
    b = {128'b0, r} % n;
    load_abn(a[127:0], b[127:0], n[127:0], 1'b1);
    run_op("w128_rev_rand", mont_model(a, b, n, 128), 1'b0, 130, 0, 0, 0, 1'b0);

    for (int i = 0; i < 10; i++) begin
      r = {$urandom, $urandom, $urandom, $urandom};
      r[127] = 1'b1;
      r[0] = 1'b1;
      n = {128'b0, r};
      r = {$urandom, $urandom, $urandom, $urandom};
      a = {128'b0, r} % n;
      r = {$urandom, $urandom, $urandom, $urandom};
      b = {128'b0, r} % n;
      load_abn(a[127:0], b[127:0], n[127:0], 1'b0);
      e = mont_model(a, b, n, 128);
      if (i == 0) begin
        run_op("w128_disturb", e, 1'b0, 130, 0, 20, 0, 1'b0);
        run_op("w128_after_disturb", e, 1'b0, 130, 0, 0, 0, 1'b0);
      end else begin
        run_op($sformatf("w128_rand[%0d]", i), e, 1'b0, 130,
               0, 0, 0, 1'b0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
